dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter AW, default 14, word-address width of the shared data memory port.
REQ-002 Parameter FIFO_DEPTH, default 4, power of two >= 2, loader write-buffer entries.
REQ-003 Port clock, input, 1, single clock for all logic; rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-high.
REQ-005 Port cpu_req, input, 1, CPU data access request: mRead or mWrite.
REQ-006 Port cpu_we, input, 1, CPU write (1) or read (0); valid with cpu_req.
REQ-007 Port cpu_addr, input, AW, CPU word address.
REQ-008 Port cpu_wdata, input, 32, CPU write data.
REQ-009 Port cpu_rdata, output, 32, read data returned to the CPU.
REQ-010 Port cpu_stall, output, 1, CPU must hold its request and PC this cycle.
REQ-011 Port upg_wen_i, input, 1, UART loader word write strobe, already synchronised to clock.
REQ-012 Port upg_adr_i, input, AW, loader word address.
REQ-013 Port upg_dat_i, input, 32, loader write data.
REQ-014 Port upg_done_i, input, 1, loader finished (1) or loading (0).
REQ-015 Port upg_full, output, 1, loader buffer full; a strobe arriving while full is dropped and counted.
REQ-016 Port mem_we, output, 1, write enable to the single-port synchronous RAM.
REQ-017 Port mem_addr, output, AW, RAM address; mem_wdata, output, 32, RAM write data.
REQ-018 Port mem_rdata, input, 32, RAM read data, valid one cycle after address.
REQ-019 Port load_busy, output, 1, high in states LOAD and DRAIN.
REQ-020 Port drop_cnt, output, 8, saturating count of dropped loader strobes.

Function
REQ-021 FSM states: LOAD, DRAIN, RUN.
- LOAD: loader owns the port; cpu_stall = cpu_req.
- LOAD -> DRAIN: upg_done_i = 1.
- DRAIN -> RUN: FIFO empty.
- RUN -> LOAD: upg_done_i = 0.
REQ-022 Loader strobes push {upg_adr_i, upg_dat_i} into the FIFO in every state; push and pop in the same cycle are both honoured, with count unchanged.
REQ-023 LOAD or DRAIN with FIFO non-empty: pop one entry per cycle; drive mem_we = 1 with the head address and data.
REQ-024 RUN priority:
- cpu_req wins the port.
- A pending FIFO entry is popped only in cycles with cpu_req = 0.
- The CPU is never stalled in RUN.
REQ-025 CPU write granted: mem_we = 1, mem_addr = cpu_addr, mem_wdata = cpu_wdata in the same cycle (combinational grant).
REQ-026 CPU read granted: mem_we = 0, mem_addr = cpu_addr; cpu_rdata is registered from mem_rdata, valid the cycle after grant, and held until the next granted read.
REQ-027 When no requester is granted, mem_we = 0 and mem_addr holds its last value.
REQ-028 upg_full = 1 when the count equals FIFO_DEPTH; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-029 drop_cnt increments on each strobe while full and saturates at 255; it clears only on reset.
REQ-030 A RUN -> LOAD transition mid-CPU-access aborts CPU grants from the next cycle; the RAM write already issued that cycle completes.

Reset
REQ-031 Reset forces:
- state LOAD, FIFO empty, drop_cnt = 0, cpu_rdata = 0
- mem_we = 0, mem_addr = 0, upg_full = 0
REQ-032 Reset asserted mid-drain discards buffered entries; no partial write is issued after reset asserts.

Configuration
REQ-033 Macro DMEM_ARB_RDBK_EN, when defined, adds three ports:
- dbg_req, input, 1
- dbg_addr, input, AW
- dbg_rdata, output, 32; registered, valid one cycle after grant, read-only
REQ-034 With DMEM_ARB_RDBK_EN, the debug requester is served in RUN at lowest priority (below CPU and FIFO) and is never served in LOAD or DRAIN.
REQ-035 Without DMEM_ARB_RDBK_EN, the dbg ports and their logic are absent; all other behaviour is identical.

Structure
REQ-036 A shared package holds:
- the state enum {LOAD, DRAIN, RUN}
- default AW and FIFO_DEPTH constants
- the grant-select encoding {GNT_NONE, GNT_CPU, GNT_FIFO, GNT_DBG}
REQ-037 The FIFO is one sub-module, arb_wr_fifo (push, pop, full, empty, head data); the FSM and grant mux stay in dmem_arbiter.

Verification
REQ-038 Reset, upg_done_i = 0, strobes to addr 0x0010..0x0013 with data 0xA0..0xA3 -> four mem_we pulses in order with matching addr/data; cpu_req = 1 during load gives cpu_stall = 1 each cycle.
REQ-039 FIFO_DEPTH = 4, pop blocked by holding the FSM in RUN with cpu_req = 1 continuously; 6 strobes -> upg_full = 1 after the 4th, drop_cnt = 2, the 4 kept entries are written once cpu_req drops.
REQ-040 RUN: CPU write 0xDEADBEEF to 0x0020, then read 0x0020 -> mem_we = 1 same cycle; cpu_rdata = 0xDEADBEEF one cycle after the read grant; cpu_stall = 0 throughout.
REQ-041 upg_done_i rises with 3 entries buffered -> DRAIN for 3 cycles, then RUN; load_busy falls the cycle RUN is entered.
REQ-042 Reset pulsed during DRAIN with 2 entries buffered -> no further mem_we, state LOAD, upg_full = 0, drop_cnt = 0.
REQ-043 DMEM_ARB_RDBK_EN defined, RUN, simultaneous cpu_req and dbg_req -> CPU granted first; dbg_rdata valid the cycle after the first idle CPU cycle.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: shared definitions for the data-memory arbiter.
//   - arb_state_e : arbiter FSM states (LOAD, DRAIN, RUN)
//   - gnt_sel_e   : which requester owns the RAM port this cycle
//   - DEF_AW / DEF_FIFO_DEPTH : default parameter values
//   - sat_inc8    : saturating 8-bit increment used by the drop counter
package dmem_arbiter_pkg;

  localparam int DEF_AW         = 14;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    DRAIN = 2'd1,
    RUN   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_FIFO = 2'd2,
    GNT_DBG  = 2'd3
  } gnt_sel_e;

  // Increment that sticks at 8'hFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/arb_wr_fifo.sv
// arb_wr_fifo: loader write buffer holding {address, data} entries.
// Ports:
//   clock, reset          : rising-edge clock, async active-high reset
//   push_i, push_adr_i,
//   push_dat_i            : enqueue request (ignored while full)
//   pop_i                 : dequeue request (ignored while empty)
//   full_o, empty_o       : occupancy flags
//   head_adr_o, head_dat_o: oldest entry, valid while !empty_o
// DEPTH must be a power of two >= 2 so the pointers wrap on their own.
module arb_wr_fifo
  import dmem_arbiter_pkg::*;
#(
  parameter int AW    = DEF_AW,
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic [AW-1:0] push_adr_i,
  input  logic [31:0]   push_dat_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW-1:0] head_adr_o,
  output logic [31:0]   head_dat_o
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [AW-1:0] adr_mem_q [DEPTH];
  logic [31:0]   dat_mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push;
  logic          do_pop;

  assign full_o     = (count_q == DEPTH_C);
  assign empty_o    = (count_q == (PW+1)'(0));
  // A push while full is dropped even if a pop happens in the same cycle.
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;
  assign head_adr_o = adr_mem_q[rd_ptr_q];
  assign head_dat_o = dat_mem_q[rd_ptr_q];

  // Next pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= PW'(0);
      rd_ptr_q <= PW'(0);
      count_q  <= (PW+1)'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care while the count says empty.
  always_ff @(posedge clock) begin
    if (do_push) begin
      adr_mem_q[wr_ptr_q] <= push_adr_i;
      dat_mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port synchronous data RAM between the CPU
// and a UART program loader (plus an optional debug read-back port).
// Ports:
//   clock, reset                  : rising-edge clock, async active-high reset
//   cpu_req/we/addr/wdata         : CPU access request
//   cpu_rdata                     : read data, valid the cycle after a read grant, then held
//   cpu_stall                     : CPU must hold its request (LOAD/DRAIN only)
//   upg_wen_i/adr_i/dat_i         : loader word-write strobe (already synchronised)
//   upg_done_i                    : loader finished
//   upg_full                      : loader buffer full
//   mem_we/addr/wdata, mem_rdata  : RAM port (read data one cycle after address)
//   load_busy                     : FSM in LOAD or DRAIN
//   drop_cnt                      : saturating count of strobes lost while full
//   dbg_req/addr, dbg_rdata       : only when DMEM_ARB_RDBK_EN is defined;
//                                   lowest-priority read-only port, RUN only
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          upg_wen_i,
  input  logic [AW-1:0] upg_adr_i,
  input  logic [31:0]   upg_dat_i,
  input  logic          upg_done_i,
  output logic          upg_full,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          load_busy,
`ifdef DMEM_ARB_RDBK_EN
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_rdata,
`endif
  output logic [7:0]    drop_cnt
);

  arb_state_e    state_q, state_d;
  gnt_sel_e      gnt;
  logic          fifo_full;
  logic          fifo_empty;
  logic [AW-1:0] head_adr;
  logic [31:0]   head_dat;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [7:0]    drop_q, drop_d;
  logic          cpu_rd_q;
  logic [31:0]   cpu_hold_q;
`ifdef DMEM_ARB_RDBK_EN
  logic          dbg_rd_q;
  logic [31:0]   dbg_hold_q;
`endif

  arb_wr_fifo #(
    .AW    (AW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push_i     (upg_wen_i),
    .push_adr_i (upg_adr_i),
    .push_dat_i (upg_dat_i),
    .pop_i      (gnt == GNT_FIFO),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_adr_o (head_adr),
    .head_dat_o (head_dat)
  );

  assign upg_full  = fifo_full;
  assign drop_cnt  = drop_q;
  assign load_busy = (state_q != RUN);
  assign cpu_stall = cpu_req && (state_q != RUN);
  // RAM output is already a register; between reads the last value is replayed.
  assign cpu_rdata = cpu_rd_q ? mem_rdata : cpu_hold_q;
`ifdef DMEM_ARB_RDBK_EN
  assign dbg_rdata = dbg_rd_q ? mem_rdata : dbg_hold_q;
`endif

  // FSM next state; DRAIN leaves once the buffer is seen empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD: begin
        if (upg_done_i) state_d = DRAIN;
        else            state_d = LOAD;
      end
      DRAIN: begin
        if (fifo_empty) state_d = RUN;
        else            state_d = DRAIN;
      end
      RUN: begin
        if (!upg_done_i) state_d = LOAD;
        else             state_d = RUN;
      end
      default: state_d = LOAD;
    endcase
  end

  // Port grant: loader owns the port outside RUN; in RUN the CPU wins, then buffer, then debug.
  always_comb begin
    gnt = GNT_NONE;
    case (state_q)
      LOAD, DRAIN: begin
        if (!fifo_empty) gnt = GNT_FIFO;
        else             gnt = GNT_NONE;
      end
      RUN: begin
        if (cpu_req) begin
          gnt = GNT_CPU;
        end else if (!fifo_empty) begin
          gnt = GNT_FIFO;
        end else begin
`ifdef DMEM_ARB_RDBK_EN
          if (dbg_req) gnt = GNT_DBG;
          else         gnt = GNT_NONE;
`else
          gnt = GNT_NONE;
`endif
        end
      end
      default: gnt = GNT_NONE;
    endcase
  end

  // RAM port mux; with no grant the address and data hold their last values.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    case (gnt)
      GNT_CPU: begin
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      GNT_FIFO: begin
        mem_we    = 1'b1;
        mem_addr  = head_adr;
        mem_wdata = head_dat;
      end
      GNT_DBG: begin
        mem_we = 1'b0;
`ifdef DMEM_ARB_RDBK_EN
        mem_addr = dbg_addr;
`endif
      end
      default: mem_we = 1'b0;
    endcase
  end

  // Drop counter next value.
  always_comb begin
    if (upg_wen_i && fifo_full) drop_d = sat_inc8(drop_q);
    else                        drop_d = drop_q;
  end

  // State, held RAM port values, read-data tracking and drop counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= LOAD;
      addr_q     <= {AW{1'b0}};
      wdata_q    <= 32'h0;
      drop_q     <= 8'h0;
      cpu_rd_q   <= 1'b0;
      cpu_hold_q <= 32'h0;
`ifdef DMEM_ARB_RDBK_EN
      dbg_rd_q   <= 1'b0;
      dbg_hold_q <= 32'h0;
`endif
    end else begin
      state_q    <= state_d;
      addr_q     <= mem_addr;
      wdata_q    <= mem_wdata;
      drop_q     <= drop_d;
      cpu_rd_q   <= (gnt == GNT_CPU) && !cpu_we;
      cpu_hold_q <= cpu_rdata;
`ifdef DMEM_ARB_RDBK_EN
      dbg_rd_q   <= (gnt == GNT_DBG);
      dbg_hold_q <= dbg_rdata;
`endif
    end
  end

endmodule
